apb_master_bridge: RTL and testbench

//  APB initiator that drives the UART register block's PSEL/PENABLE/PWRITE/PADDR/PWDATA.

---
 rtl/apb_master_bridge.sv | 137 +++++++++++++
 tb/tb_apb_master_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB initiator: takes one CPU-side command at a time and runs the SETUP/ACCESS handshake.
// Optional ACCESS timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W         = 8,
    parameter int WDATA_W        = 8,
    parameter int RDATA_W        = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [WDATA_W-1:0] cmd_wdata,
    output logic               rsp_valid,
    output logic [RDATA_W-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [ADDR_W-1:0]  PADDR,
    output logic [WDATA_W-1:0] PWDATA,
    input  logic               PREADY,
    input  logic [RDATA_W-1:0] PRDATA
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [RDATA_W-1:0] r_rsp_rdata;
    logic               r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [ADDR_W-1:0]  r_paddr;
    logic [WDATA_W-1:0] r_pwdata;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             r_rsp_err;
    logic [CNT_W-1:0] r_cnt;

    assign rsp_err = r_rsp_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign rsp_err          = 1'b0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    // cmd_ready is registered, so the first edge after reset only raises it
                    if (cmd_valid && r_cmd_ready) begin
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        r_pwdata    <= cmd_wdata;
                        r_psel      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // PREADY is checked first so it wins on the last counted cycle
                    if (PREADY) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (r_cnt == CNT_LAST) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; covers timeout or indefinite wait depending on
// whether APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

    localparam int ADDR_W  = 8;
    localparam int WDATA_W = 8;
    localparam int RDATA_W = 32;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO_CYC  = 4;
`else
    localparam int TO_CYC  = 255;
`endif

    logic               PCLK;
    logic               PRESETn;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [WDATA_W-1:0] cmd_wdata;
    logic               rsp_valid;
    logic [RDATA_W-1:0] rsp_rdata;
    logic               rsp_err;
    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [ADDR_W-1:0]  PADDR;
    logic [WDATA_W-1:0] PWDATA;
    logic               PREADY;
    logic [RDATA_W-1:0] PRDATA;

    int checks   = 0;
    int failures = 0;

    apb_master_bridge #(
        .ADDR_W        (ADDR_W),
        .WDATA_W       (WDATA_W),
        .RDATA_W       (RDATA_W),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
    endtask

    initial begin
        int n;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;

        // reset state
        tick();
        tick();
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        PRESETn = 1'b1;
        tick();
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // single write, PREADY on the first ACCESS cycle
        issue(1'b1, 8'h10, 8'hA5);
        tick();
        cmd_valid = 1'b0;
        check("wr_setup_psel", 32'(PSEL), 32'd1);
        check("wr_setup_penable", 32'(PENABLE), 32'd0);
        check("wr_setup_ready", 32'(cmd_ready), 32'd0);
        check("wr_paddr", 32'(PADDR), 32'h10);
        check("wr_pwdata", 32'(PWDATA), 32'hA5);
        check("wr_pwrite", 32'(PWRITE), 32'd1);
        PREADY = 1'b1;
        tick();
        check("wr_access_psel", 32'(PSEL), 32'd1);
        check("wr_access_penable", 32'(PENABLE), 32'd1);
        check("wr_access_rsp", 32'(rsp_valid), 32'd0);
        tick();
        PREADY = 1'b0;
        check("wr_done_psel", 32'(PSEL), 32'd0);
        check("wr_done_penable", 32'(PENABLE), 32'd0);
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_rdata", rsp_rdata, 32'd0);
        check("wr_rsp_err", 32'(rsp_err), 32'd0);
        check("wr_done_ready", 32'(cmd_ready), 32'd1);
        check("wr_idle_hold_pwdata", 32'(PWDATA), 32'hA5);
        tick();
        check("wr_rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // read with three wait states
        issue(1'b0, 8'h04, 8'h00);
        tick();
        cmd_valid = 1'b0;
        check("rd_setup_penable", 32'(PENABLE), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rd_access_psel", 32'(PSEL), 32'd1);
            check("rd_access_penable", 32'(PENABLE), 32'd1);
            check("rd_access_paddr", 32'(PADDR), 32'h04);
            check("rd_access_pwrite", 32'(PWRITE), 32'd0);
            check("rd_access_no_rsp", 32'(rsp_valid), 32'd0);
            if (i == 3) begin
                PREADY = 1'b1;
                PRDATA = 32'h0000_007F;
            end
            tick();
        end
        PREADY = 1'b0;
        PRDATA = '0;
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_rdata", rsp_rdata, 32'h7F);
        check("rd_rsp_err", 32'(rsp_err), 32'd0);
        check("rd_done_psel", 32'(PSEL), 32'd0);
        tick();
        check("rd_rdata_hold", rsp_rdata, 32'h7F);

        // stray PREADY in IDLE and SETUP
        PREADY = 1'b1;
        tick();
        check("stray_idle_rsp", 32'(rsp_valid), 32'd0);
        issue(1'b1, 8'h20, 8'h5A);
        tick();
        cmd_valid = 1'b0;
        check("stray_setup_rsp", 32'(rsp_valid), 32'd0);
        check("stray_setup_penable", 32'(PENABLE), 32'd0);
        PREADY = 1'b0;
        tick();
        check("stray_access_penable", 32'(PENABLE), 32'd1);
        check("stray_access_rsp", 32'(rsp_valid), 32'd0);
        PREADY = 1'b1;
        tick();
        PREADY = 1'b0;
        check("stray_final_rsp", 32'(rsp_valid), 32'd1);
        check("stray_final_rdata", rsp_rdata, 32'd0);
        tick();

        // back-to-back reads with cmd_valid held high
        issue(1'b0, 8'h00, 8'h00);
        tick();
        check("b2b_setup1_paddr", 32'(PADDR), 32'h00);
        cmd_addr = 8'h08;
        PREADY   = 1'b1;
        PRDATA   = 32'h3;
        tick();
        check("b2b_access1_paddr", 32'(PADDR), 32'h00);
        check("b2b_busy_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rsp1_rdata", rsp_rdata, 32'h3);
        check("b2b_rsp1_ready", 32'(cmd_ready), 32'd1);
        PRDATA = 32'h1A2;
        tick();
        cmd_valid = 1'b0;
        check("b2b_setup2_psel", 32'(PSEL), 32'd1);
        check("b2b_setup2_paddr", 32'(PADDR), 32'h08);
        check("b2b_setup2_rsp", 32'(rsp_valid), 32'd0);
        check("b2b_setup2_rdata_hold", rsp_rdata, 32'h3);
        tick();
        tick();
        PREADY = 1'b0;
        PRDATA = '0;
        check("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rsp2_rdata", rsp_rdata, 32'h1A2);
        tick();

        // slave never raises PREADY
        issue(1'b0, 8'h08, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < TO_CYC; i++) begin
            check("to_access_psel", 32'(PSEL), 32'd1);
            check("to_access_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_rsp_rdata", rsp_rdata, 32'd0);
        check("to_psel", 32'(PSEL), 32'd0);
        check("to_penable", 32'(PENABLE), 32'd0);
        tick();
        check("to_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        PRDATA = 32'h55;
`else
        n = 0;
        for (int i = 0; i < 110; i++) begin
            if (PSEL && PENABLE && !rsp_valid) n++;
            tick();
        end
        check("wait_access_cycles", 32'(n), 32'd110);
        PREADY = 1'b1;
        PRDATA = 32'h55;
        tick();
        PREADY = 1'b0;
        check("wait_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wait_rsp_rdata", rsp_rdata, 32'h55);
        check("wait_rsp_err", 32'(rsp_err), 32'd0);
        tick();
`endif

        // reset asserted mid-ACCESS
        issue(1'b0, 8'h0C, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mr_in_access", 32'(PENABLE), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mr_psel_async", 32'(PSEL), 32'd0);
        check("mr_penable_async", 32'(PENABLE), 32'd0);
        check("mr_paddr_async", 32'(PADDR), 32'd0);
        check("mr_rdata_async", rsp_rdata, 32'd0);
        PREADY = 1'b1;
        tick();
        check("mr_no_rsp", 32'(rsp_valid), 32'd0);
        check("mr_ready_low", 32'(cmd_ready), 32'd0);
        PREADY  = 1'b0;
        PRESETn = 1'b1;
        tick();
        check("mr_release_ready", 32'(cmd_ready), 32'd1);
        check("mr_release_no_rsp", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
